// File: rtl/alu_pkg.sv
// alu_pkg: shared types for the ALU issue stage.
//   alu_op_e      - ALU opcode encoding (codes 8-15 pass through unchanged)
//   issue_state_e - issue FSM states
//   alu_cmd_t     - queued command payload (op, rs1, rs2, rd, imm_sel, imm)
// The command payload is sized by ALU_WIDTH / ALU_NUM_REGS below; the
// alu_issue_stage WIDTH / NUM_REGS parameters must match them.
package alu_pkg;

   localparam int unsigned ALU_WIDTH    = 32;
   localparam int unsigned ALU_NUM_REGS = 8;
   localparam int unsigned ALU_RA_W     = $clog2(ALU_NUM_REGS);
   localparam int unsigned ALU_OP_W     = 4;

   typedef enum logic [ALU_OP_W-1:0] {
      ADD = 4'd0,
      SUB = 4'd1,
      AND = 4'd2,
      OR  = 4'd3,
      XOR = 4'd4,
      NOT = 4'd5,
      SLL = 4'd6,
      SRA = 4'd7
   } alu_op_e;

   typedef enum logic {
      IDLE = 1'b0,
      EXEC = 1'b1
   } issue_state_e;

   typedef struct packed {
      logic [ALU_OP_W-1:0]  op;
      logic [ALU_RA_W-1:0]  rs1;
      logic [ALU_RA_W-1:0]  rs2;
      logic [ALU_RA_W-1:0]  rd;
      logic                 imm_sel;
      logic [ALU_WIDTH-1:0] imm;
   } alu_cmd_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo: synchronous FIFO of alu_cmd_t commands.
//   clk, rst   - clock, synchronous active-high reset (empties the FIFO)
//   i_push     - write i_data (ignored when full, even if popping)
//   i_pop      - drop the head entry (ignored when empty)
//   o_head_c   - head entry, combinational
//   o_full_c   - FIFO holds FIFO_DEPTH entries
//   o_empty_c  - FIFO holds no entries
module alu_cmd_fifo
   import alu_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic     clk,
   input  logic     rst,
   input  logic     i_push,
   input  alu_cmd_t i_data,
   input  logic     i_pop,
   output alu_cmd_t o_head_c,
   output logic     o_full_c,
   output logic     o_empty_c
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   alu_cmd_t         r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_push;
   logic             w_pop;

   assign o_full_c  = (r_count == CNT_W'(FIFO_DEPTH));
   assign o_empty_c = (r_count == '0);
   assign w_push    = i_push && !o_full_c;
   assign w_pop     = i_pop && !o_empty_c;
   assign o_head_c  = r_mem[r_rd_ptr];

   // Storage carries no reset; validity is tracked by r_count.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_data;
   end

   // Pointers wrap naturally since FIFO_DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: queues register-addressed ALU commands, reads operands
// from a local register file, drives the combinational ALU and writes the
// result back. One operation every two cycles (IDLE issue, EXEC writeback).
//   clk, rst            - clock, synchronous active-high reset
//   cmd_*               - command valid/ready interface (cmd_ready = !full)
//   alu_operand_a/b, alu_op       - registered ALU inputs
//   alu_result/zero/carry         - ALU outputs, captured in EXEC
//   done_valid/rd/data  - one-cycle completion report
//   flag_zero/carry     - flags of the last completed operation
//   dbg_addr/dbg_data   - combinational register-file read (reg 0 reads 0)
// Optional: define ALU_ISSUE_PERF_EN to add perf_issued / perf_stall
// counters (issued operations, cycles with cmd_valid && !cmd_ready).
module alu_issue_stage
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH      = 32,
   parameter int unsigned NUM_REGS   = 8,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        cmd_valid,
   output logic                        cmd_ready,
   input  logic [3:0]                  cmd_op,
   input  logic [$clog2(NUM_REGS)-1:0] cmd_rs1,
   input  logic [$clog2(NUM_REGS)-1:0] cmd_rs2,
   input  logic [$clog2(NUM_REGS)-1:0] cmd_rd,
   input  logic                        cmd_imm_sel,
   input  logic [WIDTH-1:0]            cmd_imm,
   output logic [WIDTH-1:0]            alu_operand_a,
   output logic [WIDTH-1:0]            alu_operand_b,
   output logic [3:0]                  alu_op,
   input  logic [WIDTH-1:0]            alu_result,
   input  logic                        alu_zero,
   input  logic                        alu_carry,
   output logic                        done_valid,
   output logic [$clog2(NUM_REGS)-1:0] done_rd,
   output logic [WIDTH-1:0]            done_data,
   output logic                        flag_zero,
   output logic                        flag_carry,
   input  logic [$clog2(NUM_REGS)-1:0] dbg_addr,
   output logic [WIDTH-1:0]            dbg_data
`ifdef ALU_ISSUE_PERF_EN
   ,
   output logic [31:0]                 perf_issued,
   output logic [31:0]                 perf_stall
`endif
);

   localparam int unsigned RA_W = $clog2(NUM_REGS);

   issue_state_e     r_state;
   issue_state_e     w_next_state;
   logic             w_pop;
   logic             w_full;
   logic             w_empty;
   alu_cmd_t         w_cmd;
   alu_cmd_t         w_head;

   logic [WIDTH-1:0] r_regs [NUM_REGS];
   logic [WIDTH-1:0] r_operand_a;
   logic [WIDTH-1:0] r_operand_b;
   logic [3:0]       r_alu_op;
   logic [RA_W-1:0]  r_rd;
   logic             r_done_valid;
   logic [RA_W-1:0]  r_done_rd;
   logic [WIDTH-1:0] r_done_data;
   logic             r_flag_zero;
   logic             r_flag_carry;

   assign w_cmd = '{op: cmd_op, rs1: cmd_rs1, rs2: cmd_rs2, rd: cmd_rd,
                    imm_sel: cmd_imm_sel, imm: cmd_imm};

   alu_cmd_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .i_push    (cmd_valid),
      .i_data    (w_cmd),
      .i_pop     (w_pop),
      .o_head_c  (w_head),
      .o_full_c  (w_full),
      .o_empty_c (w_empty)
   );

   assign cmd_ready     = !w_full;
   assign alu_operand_a = r_operand_a;
   assign alu_operand_b = r_operand_b;
   assign alu_op        = r_alu_op;
   assign done_valid    = r_done_valid;
   assign done_rd       = r_done_rd;
   assign done_data     = r_done_data;
   assign flag_zero     = r_flag_zero;
   assign flag_carry    = r_flag_carry;
   assign dbg_data      = (dbg_addr == '0) ? '0 : r_regs[dbg_addr];

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next_state;
   end

   // Next state: issue whenever a command is queued, always return after EXEC
   always_comb begin
      w_next_state = r_state;
      w_pop        = 1'b0;
      case (r_state)
         IDLE: begin
            if (!w_empty) begin
               w_pop        = 1'b1;
               w_next_state = EXEC;
            end
         end
         EXEC:    w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   // Operand issue in IDLE, writeback and completion report in EXEC
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(NUM_REGS); i++) r_regs[i] <= '0;
         r_operand_a  <= '0;
         r_operand_b  <= '0;
         r_alu_op     <= '0;
         r_rd         <= '0;
         r_done_valid <= 1'b0;
         r_done_rd    <= '0;
         r_done_data  <= '0;
         r_flag_zero  <= 1'b0;
         r_flag_carry <= 1'b0;
      end else begin
         r_done_valid <= 1'b0;
         if (w_pop) begin
            r_operand_a <= r_regs[w_head.rs1];
            r_operand_b <= w_head.imm_sel ? w_head.imm : r_regs[w_head.rs2];
            r_alu_op    <= w_head.op;
            r_rd        <= w_head.rd;
         end
         if (r_state == EXEC) begin
            // Register 0 is hard-wired to zero: drop the write, still report done.
            if (r_rd != '0) r_regs[r_rd] <= alu_result;
            r_flag_zero  <= alu_zero;
            r_flag_carry <= alu_carry;
            r_done_valid <= 1'b1;
            r_done_rd    <= r_rd;
            r_done_data  <= (r_rd == '0) ? '0 : alu_result;
         end
      end
   end

`ifdef ALU_ISSUE_PERF_EN
   logic [31:0] r_perf_issued;
   logic [31:0] r_perf_stall;

   assign perf_issued = r_perf_issued;
   assign perf_stall  = r_perf_stall;

   // Free-running event counters, wrapping at 2^32
   always_ff @(posedge clk) begin
      if (rst) begin
         r_perf_issued <= '0;
         r_perf_stall  <= '0;
      end else begin
         if (r_state == IDLE && w_next_state == EXEC) r_perf_issued <= r_perf_issued + 32'(1);
         if (cmd_valid && !cmd_ready)                 r_perf_stall  <= r_perf_stall + 32'(1);
      end
   end
`endif

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Upstream sequencer for the ALU: accepts register-addressed commands over valid/ready and buffers them in a small FIFO.
- Reads operands from a local register file and drives operandA/operandB/aluOp into the combinational ALU.
- Captures result/zeroFlag/carryOut back into the register file and sticky-free flag registers.
- Sits between the command source (decoder/bench) and the ALU; completion is reported on a done port.

Parameters:
- WIDTH, 32: datapath width; must match the ALU WIDTH.
- NUM_REGS, 8: register-file entries; power of two, ≥2.
- FIFO_DEPTH, 4: command FIFO entries; power of two, ≥2.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  synchronous reset, active-high
- cmd_valid  input  1  command present
- cmd_ready  output  1  FIFO can accept a command (= !full)
- cmd_op  input  4  ALU opcode
- cmd_rs1  input  $clog2(NUM_REGS)  source A register
- cmd_rs2  input  $clog2(NUM_REGS)  source B register
- cmd_rd  input  $clog2(NUM_REGS)  destination register
- cmd_imm_sel  input  1  1 = operand B from cmd_imm instead of rs2
- cmd_imm  input  WIDTH  immediate
- alu_operand_a  output  WIDTH  to ALU operandA (registered)
- alu_operand_b  output  WIDTH  to ALU operandB (registered)
- alu_op  output  4  to ALU aluOp (registered)
- alu_result  input  WIDTH  from ALU result
- alu_zero  input  1  from ALU zeroFlag
- alu_carry  input  1  from ALU carryOut
- done_valid  output  1  one-cycle completion pulse
- done_rd  output  $clog2(NUM_REGS)  destination of completed op
- done_data  output  WIDTH  value written
- flag_zero  output  1  zero flag of last completed op
- flag_carry  output  1  carry flag of last completed op
- dbg_addr  input  $clog2(NUM_REGS)  debug read address
- dbg_data  output  WIDTH  combinational register-file read; reg 0 always reads 0

Behaviour:
- Reset (rst=1 at an edge): FIFO emptied; all registers 0; state IDLE; alu_operand_a/b=0, alu_op=0, done_valid=0, done_rd=0, done_data=0, flag_zero=0, flag_carry=0. Reset mid-operation discards the in-flight op and all queued commands, with no writeback.
- Push: cmd_valid && cmd_ready at an edge. When full, cmd_ready=0 even if a pop occurs in the same cycle (no push-through).
- FSM has two states, IDLE and EXEC.
- IDLE, FIFO non-empty: pop the head and register alu_operand_a=R[rs1] and alu_operand_b = imm_sel ? imm : R[rs2]. Register alu_op=op, latch rd, then go to EXEC.
- IDLE, FIFO empty: stay in IDLE; ALU ports hold their last values.
- EXEC, always: go to IDLE. At this edge:
  - R[rd] <= alu_result unless rd==0 (writes to reg 0 are dropped, but done still fires).
  - flag_zero <= alu_zero; flag_carry <= alu_carry.
  - done_valid <= 1; done_rd <= rd; done_data <= (rd==0 ? 0 : alu_result).
- done_valid is 0 in every other cycle.
- Latency: command accepted at edge E0 into an empty FIFO in IDLE → operands on the ALU after E1 → writeback and done_valid high after E2.
- Throughput: one op per 2 cycles. Because reads occur only in IDLE, after any prior writeback completes, there are no RAW hazards.
- A push and a pop in the same cycle are both honoured; occupancy is unchanged.
- FIFO pointers wrap modulo FIFO_DEPTH. A count or extra-bit scheme distinguishes full from empty.
- Opcodes 8–15 are forwarded unchanged; the ALU defines their result.

Optional Feature:
- Macro ALU_ISSUE_PERF_EN: adds outputs perf_issued[31:0] and perf_stall[31:0], both reset to 0.
  - perf_issued increments at each IDLE→EXEC transition.
  - perf_stall increments on each cycle with cmd_valid && !cmd_ready.
  - Both wrap at 2^32.
- Without the macro, neither port nor either counter exists; all other behaviour is identical.

Decomposition:
- Package alu_pkg holds:
  - enum alu_op_e: ADD=0, SUB=1, AND=2, OR=3, XOR=4, NOT=5, SLL=6, SRA=7;
  - enum issue_state_e: IDLE, EXEC;
  - packed struct alu_cmd_t: op, rs1, rs2, rd, imm_sel, imm.
- Sub-module alu_cmd_fifo: synchronous FIFO of alu_cmd_t with push/pop/full/empty, parameterised on FIFO_DEPTH.

Test Plan:
- Reset behaviour: after reset, dbg_data reads 0 for all regs, cmd_ready=1, done_valid stays 0 for 10 idle cycles.
- ADD with immediate, then writeback: push ADD rd=1, rs1=0, imm_sel=1, imm=5; then push ADD rd=2, rs1=1, imm_sel=1, imm=0xFFFF_FFFB.
  - Expect done for rd=1, data 5, exactly 2 edges after acceptance.
  - Then done for rd=2, data 0, with flag_zero=1 and flag_carry=1.
- Register source and reg-0 write drop: with R1=0xFF and R2=0xFF00, push OR rd=3, rs1=1, rs2=2 → R3=0x0000_FFFF. Push XOR rd=0 → done_valid=1, done_data=0, dbg_data(0)=0.
- Back-pressure: hold cmd_valid with 6 commands while the stage is busy.
  - Expect cmd_ready=0 once 4 are queued.
  - No command is lost or duplicated; done_rd sequence matches push order.
  - Consecutive done pulses are spaced exactly 2 cycles.
- Reset mid-operation: assert rst in the EXEC cycle with 3 commands queued → no done_valid, R[rd] unchanged (0), FIFO empty, cmd_ready=1 the next cycle.
- With ALU_ISSUE_PERF_EN: run the back-pressure scenario → perf_issued=6 at the end; perf_stall equals the bench-counted cycles with cmd_valid && !cmd_ready.
